// File: rtl/frodo_pkg.sv
// frodo_pkg: shared state encoding and MAC latency limits for the Macs sequencer
package frodo_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    localparam int MAC_LAT_MIN = 1;
    localparam int MAC_LAT_MAX = 15;

    // Keeps the latency inside the range the 4-bit wait counter can express
    function automatic int clamp_lat(input int lat);
        return lat < MAC_LAT_MIN ? MAC_LAT_MIN : (lat > MAC_LAT_MAX ? MAC_LAT_MAX : lat);
    endfunction

    // Wait-counter preload: WAIT lasts lat-1 cycles, the counter runs down to zero
    function automatic logic [3:0] wait_load(input int lat);
        return lat > 1 ? 4'(lat - 2) : 4'd0;
    endfunction

endpackage

// File: rtl/macs_seq_ctrl.sv
// macs_seq_ctrl: issues len beats to the Macs datapath, spaces them by MAC_LAT and hands off the result
module macs_seq_ctrl
    import frodo_pkg::*;
#(
    parameter int LEN_W   = 8,
    parameter int MAC_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             mode_in,
    input  logic             signal_in,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic             res_ready,
    output logic             res_valid,
    output logic             mac_en,
    output logic             mac_mode,
    output logic             mac_signal,
    output logic             c_sel,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int         LAT       = clamp_lat(MAC_LAT);
    localparam logic [3:0] WAIT_LOAD = wait_load(LAT);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [3:0]       r_wait;
    logic             r_mode;
    logic             r_sig;
    logic             r_last;
    logic             r_err;
    logic             w_accept;
    logic             w_final;
    logic             w_job_ok;
    logic             w_job_bad;

    assign w_accept   = op_valid && op_ready;
    assign w_final    = r_cnt == r_len - LEN_W'(1);
    assign w_job_ok   = r_state == S_IDLE && start && len != '0;
    assign w_job_bad  = r_state == S_IDLE && start && len == '0;
    assign mac_en     = w_accept;
    assign mac_mode   = r_mode;
    assign mac_signal = r_sig;
    assign c_sel      = op_ready && r_cnt != '0;
    assign done       = res_valid && res_ready;
    assign err        = r_err;
    assign busy       = r_state != S_IDLE;

    // Next-state and handshake outputs; latency 1 issues back to back, longer latencies detour through WAIT
    always_comb begin
        w_next    = r_state;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_job_ok) w_next = S_ISSUE;
            end
            S_ISSUE: begin
                op_ready = 1'b1;
                if (op_valid) w_next = LAT > 1 ? S_WAIT : (w_final ? S_OUT : S_ISSUE);
            end
            S_WAIT: begin
                if (r_wait == 4'd0) w_next = r_last ? S_OUT : S_ISSUE;
            end
            S_OUT: begin
                res_valid = 1'b1;
                if (res_ready) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, job copy, beat/wait counters and the rejected-job pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= '0;
            r_cnt   <= '0;
            r_wait  <= 4'd0;
            r_mode  <= 1'b0;
            r_sig   <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_job_bad;
            if (w_job_ok) begin
                r_len  <= len;
                r_mode <= mode_in;
                r_sig  <= signal_in;
                r_cnt  <= '0;
                r_last <= 1'b0;
            end
            if (w_accept) begin
                r_cnt  <= r_cnt + LEN_W'(1);
                r_last <= w_final;
                r_wait <= WAIT_LOAD;
            end else if (r_state == S_WAIT && r_wait != 4'd0) begin
                r_wait <= r_wait - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_macs_seq_ctrl.sv
// tb_macs_seq_ctrl: directed checks of the Macs sequencer at MAC_LAT=1 and MAC_LAT=3
module tb_macs_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] len = 8'd0;
    logic       mode_in = 1'b0;
    logic       signal_in = 1'b0;
    logic       op_valid = 1'b0;
    logic       res_ready = 1'b0;

    logic a_op_ready, a_res_valid, a_mac_en, a_mac_mode, a_mac_signal, a_c_sel, a_busy, a_done, a_err;
    logic b_op_ready, b_res_valid, b_mac_en, b_mac_mode, b_mac_signal, b_c_sel, b_busy, b_done, b_err;
    logic [8:0] a_out;
    logic [8:0] b_out;

    int n_chk = 0;
    int n_fail = 0;
    int n_en = 0;

    localparam logic [3:0] E1 [5] = '{4'b1001, 4'b1101, 4'b1101, 4'b1101, 4'b0011};
    localparam logic [3:0] E2 [7] = '{4'b1001, 4'b0001, 4'b0001, 4'b1101, 4'b0001, 4'b0001, 4'b0011};
    localparam logic       OV4 [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

    assign a_out = {a_op_ready, a_mac_en, a_mac_mode, a_mac_signal, a_c_sel, a_busy, a_res_valid, a_done, a_err};
    assign b_out = {b_op_ready, b_mac_en, b_mac_mode, b_mac_signal, b_c_sel, b_busy, b_res_valid, b_done, b_err};

    always #5 clk = ~clk;

    macs_seq_ctrl #(.LEN_W(8), .MAC_LAT(1)) u_lat1 (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode_in(mode_in), .signal_in(signal_in),
        .op_valid(op_valid), .op_ready(a_op_ready), .res_ready(res_ready), .res_valid(a_res_valid),
        .mac_en(a_mac_en), .mac_mode(a_mac_mode), .mac_signal(a_mac_signal), .c_sel(a_c_sel),
        .busy(a_busy), .done(a_done), .err(a_err)
    );

    macs_seq_ctrl #(.LEN_W(8), .MAC_LAT(3)) u_lat3 (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode_in(mode_in), .signal_in(signal_in),
        .op_valid(op_valid), .op_ready(b_op_ready), .res_ready(res_ready), .res_valid(b_res_valid),
        .mac_en(b_mac_en), .mac_mode(b_mac_mode), .mac_signal(b_mac_signal), .c_sel(b_c_sel),
        .busy(b_busy), .done(b_done), .err(b_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        op_valid = 1'b0;
        res_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_a_out", 32'(a_out), 32'd0);
        chk("rst_b_out", 32'(b_out), 32'd0);

        // len=4 at latency 1: four back-to-back beats, result in the 6th cycle counting the start cycle
        do_reset();
        @(negedge clk);
        start = 1'b1; len = 8'd4; mode_in = 1'b0; signal_in = 1'b0; op_valid = 1'b1;
        #1 chk("t1_c0_busy", 32'(a_busy), 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1 chk($sformatf("t1_c%0d", i + 1), 32'({a_mac_en, a_c_sel, a_res_valid, a_busy}), 32'(E1[i]));
        end
        res_ready = 1'b1;
        #1 chk("t1_done", 32'(a_done), 32'd1);
        @(negedge clk);
        res_ready = 1'b0;
        #1 chk("t1_idle", 32'({a_busy, a_done, a_res_valid}), 32'd0);

        // len=2 at latency 3: beats three cycles apart, result three cycles after the last beat
        do_reset();
        @(negedge clk);
        start = 1'b1; len = 8'd2; op_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1 chk($sformatf("t2_c%0d", i + 1), 32'({b_mac_en, b_c_sel, b_res_valid, b_busy}), 32'(E2[i]));
        end
        res_ready = 1'b1;
        #1 chk("t2_done", 32'(b_done), 32'd1);

        // len=0 is rejected with an err pulse and never leaves IDLE
        do_reset();
        @(negedge clk);
        start = 1'b1; len = 8'd0; op_valid = 1'b1;
        #1 chk("t3_c0_busy", 32'(a_busy), 32'd0);
        @(negedge clk);
        start = 1'b0;
        #1 chk("t3_c1", 32'({a_err, a_busy, a_mac_en}), 32'b100);
        chk("t3_c1_b_err", 32'(b_err), 32'd1);
        @(negedge clk);
        #1 chk("t3_c2", 32'({a_err, a_busy, a_mac_en}), 32'b000);

        // len=3 with stalls and job inputs toggled mid-job: mode/signal stay frozen
        do_reset();
        @(negedge clk);
        start = 1'b1; len = 8'd3; mode_in = 1'b1; signal_in = 1'b1; op_valid = 1'b0;
        n_en = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            start = 1'b0;
            op_valid = OV4[i];
            if (i == 1) begin
                mode_in = 1'b0;
                signal_in = 1'b0;
            end
            #1 chk($sformatf("t4_c%0d", i + 1), 32'({a_mac_en, a_mac_mode, a_mac_signal}), 32'({OV4[i], 2'b11}));
            n_en += int'(a_mac_en);
        end
        @(negedge clk);
        op_valid = 1'b1;
        #1 chk("t4_out", 32'({a_res_valid, a_mac_en, a_mac_mode, a_mac_signal}), 32'b1011);
        chk("t4_en_count", 32'(n_en), 32'd3);

        // Result held while res_ready stays low; start during OUT is dropped
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b1; len = 8'd5; op_valid = 1'b0;
            #1 chk($sformatf("t5_hold%0d", i), 32'({a_res_valid, a_done, a_busy, a_op_ready}), 32'b1010);
        end
        @(negedge clk);
        start = 1'b0; res_ready = 1'b1;
        #1 chk("t5_done", 32'({a_res_valid, a_done}), 32'b11);
        @(negedge clk);
        res_ready = 1'b0;
        #1 chk("t5_idle", 32'({a_busy, a_res_valid, a_done}), 32'd0);
        @(negedge clk);
        #1 chk("t5_no_queue", 32'(a_busy), 32'd0);

        // Reset mid-job abandons it; a fresh len=1 job then completes
        do_reset();
        @(negedge clk);
        start = 1'b1; len = 8'd8; mode_in = 1'b1; signal_in = 1'b1; op_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            #1 chk($sformatf("t6_beat%0d", i), 32'({a_mac_en, a_mac_mode, a_busy}), 32'b111);
        end
        @(negedge clk);
        rst = 1'b1;
        #1 chk("t6_rst_a", 32'(a_out), 32'd0);
        chk("t6_rst_b", 32'(b_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        op_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1 chk($sformatf("t6_quiet%0d", i), 32'({a_busy, a_res_valid, a_done}), 32'd0);
        end
        @(negedge clk);
        start = 1'b1; len = 8'd1; mode_in = 1'b0; signal_in = 1'b1; op_valid = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1 chk("t6_new_beat", 32'({a_mac_en, a_c_sel, a_mac_signal, a_busy}), 32'b1011);
        @(negedge clk);
        res_ready = 1'b1;
        #1 chk("t6_new_done", 32'({a_res_valid, a_done}), 32'b11);
        @(negedge clk);
        res_ready = 1'b0;
        #1 chk("t6_new_idle", 32'(a_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/macs_seq_ctrl.md
MACS_SEQ_CTRL -- requirements
Module: macs_seq_ctrl

Interface
REQ-001 SHALL have parameter LEN_W, default 8: width of the beat-count field.
REQ-002 SHALL have parameter MAC_LAT, default 1, legal range 1..15: cycles from mac_en to a valid Macs result.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: job request, sampled only in IDLE.
REQ-006 SHALL have port len, input, LEN_W: number of 4-lane beats in the job.
REQ-007 SHALL have port mode_in, input, 1: 0 = multiply-accumulate, 1 = add.
REQ-008 SHALL have port signal_in, input, 1: 0 = add, 1 = subtract.
REQ-009 SHALL have port op_valid, input, 1: the operand source presents a/b/c for one beat.
REQ-010 SHALL have port op_ready, output, 1: the controller accepts a beat.
REQ-011 SHALL have port res_ready, input, 1: the result sink accepts the 64-bit Macs result.
REQ-012 SHALL have port res_valid, output, 1: the Macs result is final for the job.
REQ-013 SHALL have port mac_en, output, 1: enable to the Macs datapath.
REQ-014 SHALL have port mac_mode, output, 1: mode to the Macs datapath.
REQ-015 SHALL have port mac_signal, output, 1: signal to the Macs datapath.
REQ-016 SHALL have port c_sel, output, 1: 0 = Macs c from operand source, 1 = Macs c from fed-back result.
REQ-017 SHALL have port busy, output, 1: high in every state except IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse when a result is handed off.
REQ-019 SHALL have port err, output, 1: one-cycle pulse when a job with len==0 is rejected.

Function
REQ-020 SHALL implement states IDLE, ISSUE, WAIT and OUT.
REQ-021 In IDLE, start with len!=0 SHALL register len, mode_in and signal_in, clear the beat counter and move to ISSUE on the next edge.
REQ-022 In IDLE, start with len==0 SHALL pulse err the following cycle and remain in IDLE.
REQ-023 mac_mode and mac_signal SHALL be driven from the registered job copy, constant for the whole job, regardless of input changes.
REQ-024 In ISSUE, op_ready SHALL be 1; in all other states op_ready SHALL be 0.
REQ-025 mac_en SHALL equal op_valid && op_ready, combinationally, in the same cycle.
REQ-026 c_sel SHALL be 0 on beat 0 and 1 on beats 1..len-1.
REQ-027 On an accepted beat, the beat counter SHALL increment.
REQ-028 After an accepted non-final beat, the FSM SHALL stay in ISSUE if MAC_LAT==1; otherwise it SHALL go to WAIT for MAC_LAT-1 cycles and then return to ISSUE.
REQ-029 After the final beat (counter==len-1), the FSM SHALL go to OUT if MAC_LAT==1; otherwise it SHALL go to WAIT for MAC_LAT-1 cycles and then go to OUT.
REQ-030 The WAIT counter SHALL be 4 bits wide.
REQ-031 Whether WAIT returns to ISSUE or proceeds to OUT SHALL be decided by a registered last-beat flag.
REQ-032 In OUT, res_valid SHALL be 1 and SHALL hold until res_ready.
REQ-033 On res_valid && res_ready, done SHALL pulse in that same cycle and the FSM SHALL return to IDLE.
REQ-034 op_valid low in ISSUE SHALL stall the FSM with no mac_en and no counter change.
REQ-035 start while busy SHALL be ignored, with no queuing.
REQ-036 Minimum job latency with MAC_LAT=1 and op_valid held high SHALL be len+2 cycles from start to res_valid.

Reset
REQ-037 rst high SHALL asynchronously force IDLE and clear the beat counter, WAIT counter, last-beat flag and job registers.
REQ-038 During reset, op_ready, mac_en, mac_mode, mac_signal, c_sel, busy, res_valid, done and err SHALL all be 0.
REQ-039 A reset asserted mid-job SHALL abandon the job; no done pulse and no res_valid SHALL follow.

Structure
REQ-040 The FSM state encoding and the MAC_LAT legal-range constant SHALL live in the shared frodo_pkg package.
REQ-041 The block SHALL be a single module with no sub-modules; it instantiates no datapath and drives the existing Macs block directly.

Verification
REQ-042 SHALL cover: MAC_LAT=1, len=4, mode=0, op_valid always 1 -> mac_en high for 4 consecutive cycles, c_sel = 0,1,1,1; res_valid 6 cycles after start; done when res_ready=1.
REQ-043 SHALL cover: MAC_LAT=3, len=2 -> mac_en pulses 3 cycles apart; res_valid 3 cycles after the second pulse.
REQ-044 SHALL cover: len=0 start -> err pulse one cycle later; busy stays 0; no mac_en.
REQ-045 SHALL cover: len=3, op_valid low 2 cycles between beats, mode_in/signal_in toggled mid-job -> exactly 3 mac_en pulses; mac_mode/mac_signal unchanged.
REQ-046 SHALL cover: res_ready held 0 for 5 cycles in OUT -> res_valid held, start ignored, done only when res_ready rises.
REQ-047 SHALL cover: rst asserted during ISSUE of a len=8 job -> all outputs 0 immediately; after release, a new len=1 job completes normally.
